// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   DEF_NUM_SRC      default number of interrupt sources
//   DEF_COOLDOWN_CYC default quiet cycles after a handler returns
//   irq_state_t      dispatch state machine encoding
package irq_pkg;

    localparam int unsigned DEF_NUM_SRC      = 4;
    localparam int unsigned DEF_COOLDOWN_CYC = 3;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSafe,
        StFire,
        StHandler,
        StCooldown
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of eligible wins.
//   eligible  in   N  candidate requests
//   winner    out  W  index of lowest set bit (0 when none)
//   any       out  1  at least one candidate present
module irq_prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] eligible,
    output logic [W-1:0] winner,
    output logic         any
);

    // Scan high to low so the last hit, the lowest index, is what remains.
    always_comb begin
        winner = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = W'(i);
            end
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches rising edges on level sources, masks them with
// a writable enable register and dispatches the lowest eligible source to fetch
// once the pipeline is safe. Handlers do not nest; after a return a fixed
// number of quiet cycles passes before the next dispatch.
//   clk, rst_n                 clock, synchronous active-low reset
//   irq_src      in  NUM_SRC   raw level requests
//   en_we/en_wdata in          enable mask write
//   stall_mem..halt in         pipeline conditions blocking dispatch
//   rti, rsi     in            handler return pulses
//   interrupt    out           one-cycle dispatch pulse
//   irq_cause    out CAUSE_W   source being serviced
//   irq_active   out           handler running
//   irq_en       out NUM_SRC   enable mask
//   irq_pending  out NUM_SRC   latched requests
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC      = DEF_NUM_SRC,
    parameter int unsigned COOLDOWN_CYC = DEF_COOLDOWN_CYC,
    localparam int unsigned CAUSE_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int unsigned CNT_W       = (COOLDOWN_CYC > 0) ? $clog2(COOLDOWN_CYC + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               stall_mem,
    input  logic               flush,
    input  logic               branch,
    input  logic               hazard,
    input  logic               halt,
    input  logic               rti,
    input  logic               rsi,
    output logic               interrupt,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic               irq_active,
    output logic [NUM_SRC-1:0] irq_en,
    output logic [NUM_SRC-1:0] irq_pending
);

    irq_state_t         state_q;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] en_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [CNT_W-1:0]   cnt_q;
    // Cleared by reset; keeps sources already high at release from
    // looking like fresh edges against the zeroed src_q.
    logic               armed_q;

    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] clr_vec;
    logic [NUM_SRC-1:0] eligible;
    logic [CAUSE_W-1:0] winner;
    logic               any;
    logic               safe;
    logic               ret;

    assign safe     = ~stall_mem & ~flush & ~branch & ~hazard & ~halt;
    assign eligible = pending_q & en_q;
    assign set_vec  = armed_q ? (irq_src & ~src_q) : '0;
    assign ret      = (state_q == StHandler) & (rti | rsi);

    always_comb begin
        clr_vec = '0;
        if (ret) begin
            clr_vec[cause_q] = 1'b1;
        end
    end

    // A new edge on the bit being retired keeps it pending.
    assign pending_d = (pending_q & ~clr_vec) | set_vec;

    irq_prio_enc #(
        .N (NUM_SRC),
        .W (CAUSE_W)
    ) u_prio_enc (
        .eligible (eligible),
        .winner   (winner),
        .any      (any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            src_q     <= '0;
            pending_q <= '0;
            en_q      <= '0;
            cause_q   <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
        end else begin
            src_q     <= irq_src;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            if (en_we) begin
                en_q <= en_wdata;
            end

            case (state_q)
                StIdle: begin
                    if (any) begin
                        if (safe) begin
                            state_q <= StFire;
                            cause_q <= winner;
                        end else begin
                            state_q <= StWaitSafe;
                        end
                    end
                end
                StWaitSafe: begin
                    if (!any) begin
                        state_q <= StIdle;
                    end else if (safe) begin
                        state_q <= StFire;
                        cause_q <= winner;
                    end
                end
                StFire: begin
                    state_q <= StHandler;
                end
                StHandler: begin
                    if (rti | rsi) begin
                        cnt_q   <= CNT_W'(COOLDOWN_CYC);
                        state_q <= StCooldown;
                    end
                end
                StCooldown: begin
                    // Leave on the edge where the counter reaches zero, so the
                    // quiet period is exactly COOLDOWN_CYC cycles long.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign interrupt   = (state_q == StFire);
    assign irq_active  = (state_q == StHandler);
    assign irq_cause   = cause_q;
    assign irq_en      = en_q;
    assign irq_pending = pending_q;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 4, number of interrupt sources; CAUSE_W = $clog2(NUM_SRC).
REQ-002 Parameter COOLDOWN_CYC, default 3, post-return quiet cycles (covers fetch interrupt redirect window).
REQ-003 clk  input  1  clock; all state changes on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 irq_src  input  NUM_SRC  raw level interrupt requests; rising edge = request.
REQ-006 en_we  input  1  write strobe for enable mask.
REQ-007 en_wdata  input  NUM_SRC  new enable mask.
REQ-008 stall_mem, flush, branch, hazard, halt  input  1 each  pipeline conditions that block dispatch.
REQ-009 rti, rsi  input  1 each  handler-return pulses from execute.
REQ-010 interrupt  output  1  one-cycle dispatch pulse to fetch.
REQ-011 irq_cause  output  CAUSE_W  index of source being serviced.
REQ-012 irq_active  output  1  high while a handler runs.
REQ-013 irq_en  output  NUM_SRC  current enable mask.
REQ-014 irq_pending  output  NUM_SRC  latched pending requests.

Function
REQ-015 Registered copy src_q of irq_src; pending[i] sets at the edge where irq_src[i]=1 and src_q[i]=0, regardless of enable.
REQ-016 Set and clear of the same pending bit in one cycle: set wins.
REQ-017 Eligible = pending & irq_en; winner = lowest eligible index (fixed priority).
REQ-018 safe = ~stall_mem & ~flush & ~branch & ~hazard & ~halt.
REQ-019 States: IDLE, WAIT_SAFE, FIRE, HANDLER, COOLDOWN.
REQ-020 IDLE: eligible nonzero and safe -> FIRE; eligible nonzero and not safe -> WAIT_SAFE; else stay.
REQ-021 WAIT_SAFE: eligible zero -> IDLE; safe -> FIRE; else stay.
REQ-022 irq_cause latched with winner on entry to FIRE; held unchanged until the next FIRE entry.
REQ-023 FIRE: interrupt=1 for exactly one cycle; unconditional -> HANDLER.
REQ-024 HANDLER: irq_active=1; rti or rsi (either or both) -> clears pending[irq_cause], loads counter with COOLDOWN_CYC, -> COOLDOWN.
REQ-025 COOLDOWN: counter decrements each cycle; at zero -> IDLE; no dispatch; new edges still latch.
REQ-026 rti/rsi outside HANDLER ignored; no nesting: requests arriving in FIRE/HANDLER/COOLDOWN remain pending.
REQ-027 en_we updates irq_en at the next edge, in any state; clearing the serviced bit does not abort HANDLER.
REQ-028 Latency: edge sampled cycle 0, safe and idle -> pending visible cycle 1, interrupt high cycle 2.
REQ-029 Minimum spacing of two interrupt pulses: FIRE + 1 HANDLER cycle + COOLDOWN_CYC + 1.

Reset
REQ-030 Reset: state IDLE, pending 0, src_q 0, irq_en 0, irq_cause 0, counter 0, interrupt 0, irq_active 0.
REQ-031 Reset asserted mid-handler returns to IDLE and discards all pending requests; sources already high at release do not trigger until they drop and rise again.

Structure
REQ-032 Package irq_pkg holds state enum irq_state_t, NUM_SRC, COOLDOWN_CYC defaults.
REQ-033 Sub-module irq_prio_enc: combinational lowest-index priority encoder (eligible -> winner index, any).
REQ-034 Outputs interrupt and irq_active decoded from registered state only; no input-to-output combinational path.

Verification
REQ-035 irq_en=4'b1111, safe, pulse irq_src[2] at cycle 0 -> interrupt high cycle 2 only, irq_cause=2, irq_active from cycle 3.
REQ-036 Edges on src 3 and 1 same cycle -> cause 1 serviced first; after rsi + 3 cooldown cycles, cause 3 dispatched.
REQ-037 Pending src 0 with stall_mem held high 5 cycles -> state WAIT_SAFE, interrupt only in the cycle after stall_mem drops.
REQ-038 irq_en=0, edge src 1 -> pending=4'b0010, no interrupt; write irq_en=4'b0010 -> interrupt 1 cycle after state sees enable.
REQ-039 rti during IDLE -> no effect; edge on src 0 during HANDLER -> pending[0]=1, no interrupt until COOLDOWN ends.
REQ-040 rst_n low for 1 cycle during HANDLER with pending=4'b1010 -> all outputs zero, src held high afterwards produces no interrupt.
